// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  localparam int INSTR_W  = 32;
  localparam int PC_INC   = 4;
  localparam int PC_MAX_W = 64;

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_DROP} fetch_state_t;

  // The PC field is sized for the widest supported address; narrower builds zero-extend.
  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus, datapath handshake and debug/perf signals of the fetch unit.
interface instr_fetch_unit_if #(parameter int ADDR_W = 64);
  logic                         oIMemReq;
  logic [ADDR_W-1:0]            oIMemAddr;
  logic                         iIMemValid;
  logic [fetch_pkg::INSTR_W-1:0] iIMemData;
  logic                         oInstrValid;
  logic [fetch_pkg::INSTR_W-1:0] oInstruction;
  logic [ADDR_W-1:0]            oInstrPC;
  logic                         iInstrReady;
  logic                         iRedirect;
  logic [ADDR_W-1:0]            iRedirectPC;
  logic [ADDR_W-1:0]            oFetchPC;
  logic [31:0]                  oPerfIssued;
  logic [31:0]                  oPerfDropped;

  modport master (
    output oIMemReq, oIMemAddr, oInstrValid, oInstruction, oInstrPC, oFetchPC,
           oPerfIssued, oPerfDropped,
    input  iIMemValid, iIMemData, iInstrReady, iRedirect, iRedirectPC
  );

  modport slave (
    input  oIMemReq, oIMemAddr, oInstrValid, oInstruction, oInstrPC, oFetchPC,
           oPerfIssued, oPerfDropped,
    output iIMemValid, iIMemData, iInstrReady, iRedirect, iRedirectPC
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is read combinationally from storage.
module fetch_fifo #(
  parameter  int WIDTH = 96,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wrPtr, rdPtr;
  logic                        doPop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtr];

  // Flush wins over push/pop; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= wrData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(doPop);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: one outstanding imem request, tagged instruction buffer, redirect squash.
// Optional saturating request/drop counters under `FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int                ADDR_W     = 64,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                iCLK,
  input  logic                iRST,
  instr_fetch_unit_if.master  bus
);
  import fetch_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state, nextState;
  logic [ADDR_W-1:0] fetchPc, redirTarget, memAddr;
  logic              memReq, issue, respOk, push, pop;
  logic              fifoFull, fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;
  fetch_entry_t      pushEntry, headEntry;

  assign redirTarget = {bus.iRedirectPC[ADDR_W-1:2], 2'b00};
  assign pop         = !fifoEmpty && bus.iInstrReady;
  assign push        = respOk && (!fifoFull || pop);
  // fetchPc already advanced past the outstanding request.
  assign pushEntry.pc    = PC_MAX_W'(fetchPc - ADDR_W'(PC_INC));
  assign pushEntry.instr = bus.iIMemData;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= S_ISSUE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      S_ISSUE: if (issue) nextState = S_WAIT;
      S_WAIT: begin
        if (bus.iIMemValid)     nextState = S_ISSUE;
        else if (bus.iRedirect) nextState = S_DROP;
      end
      S_DROP:  if (bus.iIMemValid) nextState = S_ISSUE;
      default: nextState = S_ISSUE;
    endcase
  end

  always_comb begin
    issue  = 1'b0;
    respOk = 1'b0;
    unique case (state)
      S_ISSUE: issue  = !bus.iRedirect && (fifoCount < CNT_W'(FIFO_DEPTH));
      S_WAIT:  respOk = bus.iIMemValid && !bus.iRedirect;
      default: ;
    endcase
  end

  // Request strobe/address are registered so reset drives them low directly.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      fetchPc <= RESET_PC;
      memReq  <= 1'b0;
      memAddr <= '0;
    end else begin
      memReq <= issue;
      if (issue) memAddr <= fetchPc;
      if (bus.iRedirect) fetchPc <= redirTarget;
      else if (issue)    fetchPc <= fetchPc + ADDR_W'(PC_INC);
    end
  end

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) uBuf (
    .clk    (iCLK),
    .rst    (iRST),
    .flush  (bus.iRedirect),
    .push   (push),
    .pop    (pop),
    .wrData (pushEntry),
    .rdData (headEntry),
    .count  (fifoCount),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  assign bus.oIMemReq     = memReq;
  assign bus.oIMemAddr    = memAddr;
  assign bus.oInstrValid  = !fifoEmpty;
  assign bus.oInstruction = headEntry.instr;
  assign bus.oInstrPC     = headEntry.pc[ADDR_W-1:0];
  assign bus.oFetchPC     = fetchPc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfIssued, perfDropped;
  logic        dropResp;

  assign dropResp = bus.iIMemValid &&
                    ((state == S_DROP) || (state == S_WAIT && bus.iRedirect));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      perfIssued  <= '0;
      perfDropped <= '0;
    end else begin
      if (issue && perfIssued != '1)     perfIssued  <= perfIssued + 1'b1;
      if (dropResp && perfDropped != '1) perfDropped <= perfDropped + 1'b1;
    end
  end

  assign bus.oPerfIssued  = perfIssued;
  assign bus.oPerfDropped = perfDropped;
`else
  assign bus.oPerfIssued  = '0;
  assign bus.oPerfDropped = '0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency instruction memory model.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_fetch_unit_if #(.ADDR_W(64)) bus();

  instr_fetch_unit #(.ADDR_W(64), .FIFO_DEPTH(2), .RESET_PC(64'h0)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } pop_t;

  typedef struct {
    int          lat;
    logic [63:0] addr;
    logic [31:0] instr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          memLat = 1;
  int          memCnt = 0;
  logic [63:0] pendAddr = '0;
  logic [63:0] reqQ[$];
  pop_t        popQ[$];
  vec_t        vecs[5];

`ifdef FETCH_PERF_CNT_EN
  localparam logic [63:0] PERF_ON = 64'd1;
`else
  localparam logic [63:0] PERF_ON = 64'd0;
`endif

  function automatic logic [31:0] word(input logic [63:0] a);
    return 32'hD500_0000 ^ a[31:0];
  endfunction

  function automatic logic [63:0] reqAt(input int i);
    return (i < reqQ.size()) ? reqQ[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic pop_t popAt(input int i);
    return (i < popQ.size()) ? popQ[i] : '{pc: 64'hDEAD, instr: 32'hDEAD};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: log the pop decided this cycle, cross the edge, then run the memory model.
  task automatic step();
    if (bus.oInstrValid && bus.iInstrReady) popQ.push_back({bus.oInstrPC, bus.oInstruction});
    @(posedge clk);
    #1;
    bus.iIMemValid = 1'b0;
    if (rst) memCnt = 0;
    else begin
      if (memCnt > 0) begin
        memCnt--;
        if (memCnt == 0) begin
          bus.iIMemValid = 1'b1;
          bus.iIMemData  = word(pendAddr);
        end
      end
      if (bus.oIMemReq) begin
        reqQ.push_back(bus.oIMemAddr);
        pendAddr = bus.oIMemAddr;
        memCnt   = memLat;
      end
    end
  endtask

  task automatic waitReq(input string name, input int n);
    for (int k = 0; k < 60 && reqQ.size() < n; k++) step();
    chk({name, " req count"}, 64'(reqQ.size()), 64'(n));
  endtask

  task automatic waitPop(input string name, input int n);
    for (int k = 0; k < 60 && popQ.size() < n; k++) step();
    chk({name, " pop count"}, 64'(popQ.size()), 64'(n));
  endtask

  task automatic checkZero(input string name);
    chk({name, " req"},      64'(bus.oIMemReq), 64'h0);
    chk({name, " addr"},     bus.oIMemAddr, 64'h0);
    chk({name, " valid"},    64'(bus.oInstrValid), 64'h0);
    chk({name, " instr"},    64'(bus.oInstruction), 64'h0);
    chk({name, " pc"},       bus.oInstrPC, 64'h0);
    chk({name, " fetchpc"},  bus.oFetchPC, 64'h0);
    chk({name, " issued"},   64'(bus.oPerfIssued), 64'h0);
    chk({name, " dropped"},  64'(bus.oPerfDropped), 64'h0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.iRedirect   = 1'b0;
    bus.iRedirectPC = '0;
    bus.iInstrReady = 1'b0;
    bus.iIMemValid  = 1'b0;
    bus.iIMemData   = '0;
    step();
    step();
    checkZero("reset");
    rst = 1'b0;
    reqQ.delete();
    popQ.delete();
  endtask

  initial begin
    vecs[0] = '{lat: 1, addr: 64'h00, instr: 32'hD500_0000};
    vecs[1] = '{lat: 1, addr: 64'h04, instr: 32'hD500_0004};
    vecs[2] = '{lat: 1, addr: 64'h08, instr: 32'hD500_0008};
    vecs[3] = '{lat: 2, addr: 64'h0C, instr: 32'hD500_000C};
    vecs[4] = '{lat: 4, addr: 64'h10, instr: 32'hD500_0010};

    // Streaming with the datapath always ready.
    memLat = vecs[0].lat;
    doReset();
    bus.iInstrReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      waitReq($sformatf("stream%0d", i), i + 1);
      chk($sformatf("stream%0d addr", i), reqAt(i), vecs[i].addr);
      if (i < 4) memLat = vecs[i+1].lat;
      waitPop($sformatf("stream%0d", i), i + 1);
      chk($sformatf("stream%0d pc", i), popAt(i).pc, vecs[i].addr);
      chk($sformatf("stream%0d instr", i), 64'(popAt(i).instr), 64'(vecs[i].instr));
    end

    // Back-pressure: buffer fills after two requests, one pop frees a slot.
    memLat = 3;
    doReset();
    repeat (25) step();
    chk("bp req count", 64'(reqQ.size()), 64'd2);
    chk("bp req1", reqAt(1), 64'h4);
    chk("bp valid", 64'(bus.oInstrValid), 64'h1);
    chk("bp head pc", bus.oInstrPC, 64'h0);
    bus.iInstrReady = 1'b1;
    step();
    bus.iInstrReady = 1'b0;
    repeat (12) step();
    chk("bp req count after pop", 64'(reqQ.size()), 64'd3);
    chk("bp req2", reqAt(2), 64'h8);
    chk("bp popped pc", popAt(0).pc, 64'h0);
    chk("bp popped instr", 64'(popAt(0).instr), 64'hD500_0000);

    // Redirect while a request is outstanding: late response must be dropped.
    memLat = 3;
    doReset();
    bus.iInstrReady = 1'b1;
    waitReq("wait-redir", 2);
    bus.iRedirect   = 1'b1;
    bus.iRedirectPC = 64'h103;
    step();
    bus.iRedirect = 1'b0;
    chk("wait-redir valid", 64'(bus.oInstrValid), 64'h0);
    chk("wait-redir fetchpc", bus.oFetchPC, 64'h100);
    waitReq("wait-redir next", 3);
    chk("wait-redir req", reqAt(2), 64'h100);
    chk("wait-redir issued", 64'(bus.oPerfIssued), PERF_ON * 3);
    chk("wait-redir dropped", 64'(bus.oPerfDropped), PERF_ON);
    waitPop("wait-redir", 2);
    chk("wait-redir pop pc", popAt(1).pc, 64'h100);
    chk("wait-redir pop instr", 64'(popAt(1).instr), 64'hD500_0100);

    // Redirect coincident with the response and a pop: no drop state.
    memLat = 2;
    doReset();
    for (int k = 0; k < 40 && !(reqQ.size() >= 2 && bus.iIMemValid); k++) step();
    chk("coinc resp seen", 64'(bus.iIMemValid), 64'h1);
    chk("coinc head pc", bus.oInstrPC, 64'h0);
    bus.iInstrReady = 1'b1;
    bus.iRedirect   = 1'b1;
    bus.iRedirectPC = 64'h200;
    step();
    bus.iRedirect = 1'b0;
    chk("coinc valid", 64'(bus.oInstrValid), 64'h0);
    chk("coinc fetchpc", bus.oFetchPC, 64'h200);
    waitReq("coinc next", 3);
    chk("coinc req", reqAt(2), 64'h200);
    chk("coinc dropped", 64'(bus.oPerfDropped), PERF_ON);

    // Asynchronous reset between clock edges while waiting on memory.
    memLat = 5;
    doReset();
    bus.iInstrReady = 1'b1;
    waitReq("async", 2);
    chk("async pre addr", bus.oIMemAddr, 64'h4);
    #3;
    rst = 1'b1;
    #1;
    checkZero("async");
    step();
    rst = 1'b0;
    reqQ.delete();
    popQ.delete();
    waitReq("async restart", 1);
    chk("async restart addr", reqAt(0), 64'h0);

    // Redirect to the top word: fetch PC wraps to zero.
    memLat = 1;
    doReset();
    bus.iInstrReady = 1'b1;
    bus.iRedirect   = 1'b1;
    bus.iRedirectPC = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    bus.iRedirect = 1'b0;
    chk("wrap fetchpc", bus.oFetchPC, 64'hFFFF_FFFF_FFFF_FFFC);
    waitReq("wrap", 2);
    chk("wrap req0", reqAt(0), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap req1", reqAt(1), 64'h0);
    waitPop("wrap", 1);
    chk("wrap pop pc", popAt(0).pc, 64'hFFFF_FFFF_FFFF_FFFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream fetch stage for the LEGv8/ARM processor datapath. Owns the fetch PC and issues word requests to an instruction memory with variable response latency. Buffers returned instructions, tagged with their PC, in a small FIFO. Hands them to the datapath over a valid/ready handshake and squashes in-flight fetches when the datapath redirects on a taken branch.

Parameters:
ADDR_W, 64, width of PC and memory address
FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2
RESET_PC, 64'h0, fetch PC value after reset

Ports:
iCLK  in  1  clock, all state on rising edge
iRST  in  1  reset, asynchronous, active-high
oIMemReq  out  1  one-cycle request strobe to instruction memory
oIMemAddr  out  ADDR_W  request address, valid with oIMemReq
iIMemValid  in  1  response strobe, one cycle per request
iIMemData  in  32  instruction word, valid with iIMemValid
oInstrValid  out  1  FIFO head holds an instruction
oInstruction  out  32  head instruction word
oInstrPC  out  ADDR_W  PC of head instruction
iInstrReady  in  1  datapath consumes head this cycle
iRedirect  in  1  taken branch or jump; flush and refetch
iRedirectPC  in  ADDR_W  redirect target (datapath branch PC)
oFetchPC  out  ADDR_W  current fetch pointer, for display/debug
oPerfIssued  out  32  requests issued (see Optional Feature)
oPerfDropped  out  32  responses discarded (see Optional Feature)

Behaviour:
- Reset (async, any state): fetch PC = RESET_PC; FIFO empty; FSM = S_ISSUE; oIMemReq=0, oIMemAddr=0, oInstrValid=0, oInstruction=0, oInstrPC=0, counters=0.
- At most one outstanding memory request.
- FSM S_ISSUE:
  - iRedirect: fetch PC = {iRedirectPC[63:2],2'b00}; FIFO flushed; no request this cycle; stay in S_ISSUE.
  - Otherwise, if FIFO count < FIFO_DEPTH: assert oIMemReq with oIMemAddr = fetch PC for exactly one cycle; fetch PC += 4 (wraps mod 2^ADDR_W); go to S_WAIT.
  - Otherwise (FIFO full): stay in S_ISSUE.
- FSM S_WAIT:
  - iIMemValid without iRedirect: push {fetch PC-4, iIMemData}; go to S_ISSUE.
  - iRedirect without iIMemValid: flush FIFO, load the target, go to S_DROP.
  - iRedirect with iIMemValid together: discard the response, flush, load the target, go to S_ISSUE.
- FSM S_DROP:
  - iIMemValid: discard; go to S_ISSUE.
  - A further iRedirect here only reloads the target; stay in S_DROP.
- Handshake and FIFO:
  - Pop when oInstrValid && iInstrReady.
  - Push and pop in the same cycle are legal; count is unchanged.
  - iRedirect beats a simultaneous pop: the FIFO is emptied and the pop has no further effect.
  - Head outputs come straight from FIFO storage: 0-cycle read.
  - oInstrValid is high the cycle after a push into an empty FIFO.
- Latency: instruction visible at the head 1 cycle after iIMemValid. Minimum request-to-request spacing is 2 cycles plus memory latency.
- iIMemValid in S_ISSUE (protocol error): ignored.
- FIFO wraps its pointers modulo FIFO_DEPTH; count never exceeds FIFO_DEPTH.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: 32-bit saturating counters.
  - oPerfIssued increments on each oIMemReq.
  - oPerfDropped increments on each discarded response (S_DROP, or redirect coincident with iIMemValid).
  - Both cleared by iRST.
- Undefined: no counter logic; both ports tied to 0.

Decomposition:
- Package fetch_pkg: FSM state enum {S_ISSUE, S_WAIT, S_DROP}, INSTR_W=32, PC_INC=4, FIFO entry struct {pc, instr}.
- One sub-module: fetch_fifo, a parameterised synchronous FIFO with flush, push/pop, count, full/empty. It is instantiated once for the instruction buffer.

Test Plan:
- Reset, memory latency 1, iInstrReady=1 -> oIMemAddr sequence 0x0,0x4,0x8; oInstrPC 0x0,0x4,0x8 with matching words; oInstrValid=0 during reset.
- iInstrReady=0, latency 3 -> exactly 2 requests (0x0, 0x4), then oIMemReq stays 0; raising ready for 1 cycle allows a request to 0x8.
- Redirect to 0x103 while request 0x4 outstanding (S_WAIT) -> FIFO empty next cycle; late response for 0x4 discarded; next request 0x100; oPerfDropped=1 when macro defined.
- Redirect to 0x200 on the same cycle as iIMemValid and a pop -> response discarded, no S_DROP, next oIMemAddr=0x200, oInstrValid=0.
- Reset asserted mid-S_WAIT, async between clock edges -> outputs 0 immediately; after release the first request is at RESET_PC.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC -> requests 0x...FFFC then 0x0 (wrap).
